// File: rtl/shifter_pkg.sv
// Shared types and constants for the 8-bit logical barrel shifter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package shifter_pkg;

  localparam int DATA_W  = 8;
  localparam int SHAMT_W = 3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/shifter_core.sv
// Combinational log-stage logical barrel shifter (stages of 1, 2, 4), zero fill.
// Latency: 0 cycles; pure combinational path of SHAMT_W mux stages plus direction muxes.
// Backpressure: none, output follows inputs continuously.
module shifter_core
  import shifter_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] amt_i,
  input  logic               dir_i,
  output logic [WIDTH-1:0]   data_o
);

  // Right shifts reuse the left-shift stages by mirroring the word on entry and exit.
  logic [WIDTH-1:0] fwd;
  logic [WIDTH-1:0] rev_in;
  logic [WIDTH-1:0] rev_out;
  logic [WIDTH-1:0] stg [SHAMT_W+1];

  // Mirror the operand when shifting right so one left-shift network serves both directions.
  always_comb begin
    rev_in = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rev_in[i] = data_i[WIDTH-1-i];
    end
    fwd = (dir_i == DIR_RIGHT) ? rev_in : data_i;
  end

  // Stage s shifts left by 2**s when amt_i[s] is set; vacated bits fill with zero.
  always_comb begin
    stg[0] = fwd;
    for (int s = 0; s < SHAMT_W; s++) begin
      stg[s+1] = amt_i[s] ? (stg[s] << (1 << s)) : stg[s];
    end
  end

  // Undo the mirror for right shifts.
  always_comb begin
    rev_out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rev_out[i] = stg[SHAMT_W][WIDTH-1-i];
    end
    data_o = (dir_i == DIR_RIGHT) ? rev_out : stg[SHAMT_W];
  end

endmodule

// File: rtl/shifter_8bit.sv
// Registered 8-bit logical barrel shifter: left/right by 0-7, zero fill, no flags.
// Latency: 1 cycle; result of edge N inputs is visible after edge N, new result every cycle.
// Backpressure: none; no handshake, data_out reloads on every non-reset edge.
module shifter_8bit
  import shifter_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shift_amt,
  input  logic               dir,
  output logic [WIDTH-1:0]   data_out
);

  logic [WIDTH-1:0] data_out_d;
  logic [WIDTH-1:0] data_out_q;

  shifter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .data_i (data_in),
    .amt_i  (shift_amt),
    .dir_i  (dir),
    .data_o (data_out_d)
  );

  // Output register: synchronous reset drops any pending result and forces zero.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      data_out_q <= '0;
    end else begin
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_shifter_8bit.sv
// Self-checking bench for shifter_8bit: directed table, corner sequences, random and exhaustive sweep.
// Latency: checks each result #1 after the edge that sampled its inputs.
// Backpressure: none; inputs change every cycle.
module tb_shifter_8bit;

  logic       Clock;
  logic       Reset;
  logic [7:0] data_in;
  logic [2:0] shift_amt;
  logic       dir;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] din;
    logic [2:0] amt;
    logic       dr;
    logic [7:0] expv;
    string      name;
  } vec_t;

  vec_t vecs [9];

  shifter_8bit #(.WIDTH(8)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .data_in   (data_in),
    .shift_amt (shift_amt),
    .dir       (dir),
    .data_out  (data_out)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference: plain logical shift truncated to 8 bits.
  function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] a, input logic r);
    logic [7:0] t;
    if (r) t = d >> a;
    else   t = d << a;
    return t;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Drive one set of inputs, wait for the sampling edge, then look at the result.
  task automatic step(input logic rst, input logic [7:0] d, input logic [2:0] a, input logic r);
    Reset     = rst;
    data_in   = d;
    shift_amt = a;
    dir       = r;
    @(posedge Clock);
    #1;
  endtask

  initial begin
    vecs[0] = '{8'hAA, 3'd1, 1'b0, 8'h54, "aa_l1"};
    vecs[1] = '{8'hAA, 3'd2, 1'b1, 8'h2A, "aa_r2"};
    vecs[2] = '{8'hF0, 3'd3, 1'b0, 8'h80, "f0_l3"};
    vecs[3] = '{8'h0F, 3'd1, 1'b1, 8'h07, "0f_r1"};
    vecs[4] = '{8'h81, 3'd7, 1'b0, 8'h80, "81_l7"};
    vecs[5] = '{8'h81, 3'd7, 1'b1, 8'h01, "81_r7"};
    vecs[6] = '{8'hFF, 3'd0, 1'b0, 8'hFF, "ff_l0"};
    vecs[7] = '{8'hFF, 3'd0, 1'b1, 8'hFF, "ff_r0"};
    vecs[8] = '{8'h5A, 3'd4, 1'b1, 8'h05, "5a_r4"};

    Reset = 1'b1; data_in = 8'h00; shift_amt = 3'd0; dir = 1'b0;
    #2;

    // Reset held two cycles with busy inputs.
    step(1'b1, 8'hFF, 3'd0, 1'b0);
    check("reset_cyc1", data_out, 8'h00);
    step(1'b1, 8'hC3, 3'd1, 1'b1);
    check("reset_cyc2", data_out, 8'h00);
    step(1'b0, 8'h3C, 3'd0, 1'b0);
    check("first_after_reset", data_out, 8'h3C);

    // Directed table, applied back to back.
    for (int i = 0; i < 9; i++) begin
      step(1'b0, vecs[i].din, vecs[i].amt, vecs[i].dr);
      check(vecs[i].name, data_out, vecs[i].expv);
    end

    // Mid-stream reset: pending inputs dropped, output zero, then resume.
    step(1'b0, 8'hAA, 3'd1, 1'b0);
    check("mid_pre", data_out, 8'h54);
    step(1'b1, 8'hAA, 3'd2, 1'b1);
    check("mid_reset", data_out, 8'h00);
    step(1'b0, 8'hF0, 3'd3, 1'b0);
    check("mid_resume1", data_out, 8'h80);
    step(1'b0, 8'h0F, 3'd1, 1'b1);
    check("mid_resume2", data_out, 8'h07);

    // Random back-to-back stream, every input changing every cycle.
    for (int i = 0; i < 200; i++) begin
      logic [7:0] d;
      logic [2:0] a;
      logic       r;
      d = 8'($urandom);
      a = 3'($urandom_range(7, 0));
      r = 1'($urandom);
      step(1'b0, d, a, r);
      check("random_stream", data_out, model(d, a, r));
    end

    // Exhaustive sweep of every data/amount/direction combination.
    for (int r = 0; r < 2; r++) begin
      for (int a = 0; a < 8; a++) begin
        for (int d = 0; d < 256; d++) begin
          step(1'b0, 8'(d), 3'(a), 1'(r));
          check("sweep", data_out, model(8'(d), 3'(a), 1'(r)));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
